// File: rtl/branch_comp_pkg.sv
// rtl/branch_comp_pkg.sv - shared CPU constants for the branch comparator
//
// Purpose: holds the machine word width shared by CPU datapath blocks.
// Ports:   none (package).
package branch_comp_pkg;

  localparam int XLEN = 32;

endpackage : branch_comp_pkg

// File: rtl/br_mag_cmp.sv
// rtl/br_mag_cmp.sv - equality and signed/unsigned magnitude compare
//
// Purpose: combinational compare of two operands using one WIDTH+1-bit
//          subtraction for the less-than result.
// Ports:
//   a           in  WIDTH  left operand
//   b           in  WIDTH  right operand
//   is_unsigned in  1      1 = unsigned compare, 0 = two's complement
//   eq          out 1      a == b
//   lt          out 1      a < b under the selected mode
module br_mag_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH:0] diff;
  logic           borrow;
  logic           sign_differs;

  // Zero-extend both operands so the extra top bit of the difference is
  // the borrow out of the unsigned subtraction.
  assign diff         = {1'b0, a} - {1'b0, b};
  assign borrow       = diff[WIDTH];
  assign sign_differs = a[WIDTH-1] ^ b[WIDTH-1];

  always_comb begin
    eq = (a == b);
    lt = 1'b0;
    if (is_unsigned) begin
      lt = borrow;
    end else if (sign_differs) begin
      // Opposite signs: the negative one is smaller.
      lt = a[WIDTH-1];
    end else begin
      // Same signs cannot overflow, so the difference sign is exact.
      lt = diff[WIDTH-1];
    end
  end

endmodule : br_mag_cmp

// File: rtl/branch_comp.sv
// rtl/branch_comp.sv - branch comparator with registered copies of results
//
// Purpose: combinational breq/brlt for branch resolution plus one-cycle
//          registered versions.
// Ports:
//   clk     in  1      clock, registered outputs update on rising edge
//   rst     in  1      asynchronous active-high reset of registered outputs
//   brdata1 in  WIDTH  left operand (rs1)
//   brdata2 in  WIDTH  right operand (rs2)
//   brun    in  1      1 = unsigned compare, 0 = signed compare
//   breq    out 1      combinational equality
//   brlt    out 1      combinational less-than
//   breq_q  out 1      breq delayed one clock
//   brlt_q  out 1      brlt delayed one clock
module branch_comp
  import branch_comp_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] brdata1,
  input  logic [WIDTH-1:0] brdata2,
  input  logic             brun,
  output logic             breq,
  output logic             brlt,
  output logic             breq_q,
  output logic             brlt_q
);

  br_mag_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a          (brdata1),
    .b          (brdata2),
    .is_unsigned(brun),
    .eq         (breq),
    .lt         (brlt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breq_q <= 1'b0;
      brlt_q <= 1'b0;
    end else begin
      breq_q <= breq;
      brlt_q <= brlt;
    end
  end

endmodule : branch_comp

// File: tb/tb_branch_comp.sv
// tb/tb_branch_comp.sv - directed and randomized checks of branch_comp
module tb_branch_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] brdata1;
  logic [31:0] brdata2;
  logic        brun;
  logic        breq;
  logic        brlt;
  logic        breq_q;
  logic        brlt_q;

  int total = 0;
  int bad   = 0;

  branch_comp #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .brdata1(brdata1),
    .brdata2(brdata2),
    .brun   (brun),
    .breq   (breq),
    .brlt   (brlt),
    .breq_q (breq_q),
    .brlt_q (brlt_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic u);
    brdata1 = a;
    brdata2 = b;
    brun    = u;
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ru;
    logic        exp_lt;

    rst = 1'b1;
    apply(32'd10, 32'd10, 1'b0);
    chk("reset_breq_q", breq_q, 1'b0);
    chk("reset_brlt_q", brlt_q, 1'b0);
    // Reset must not disturb the combinational path.
    chk("rst_eq_breq", breq, 1'b1);
    chk("rst_eq_brlt", brlt, 1'b0);

    apply(32'd10, 32'd10, 1'b1);
    chk("eq_u_breq", breq, 1'b1);
    chk("eq_u_brlt", brlt, 1'b0);

    apply(32'd10, 32'd20, 1'b1);
    chk("u_10_20_brlt", brlt, 1'b1);
    chk("u_10_20_breq", breq, 1'b0);
    apply(32'd30, 32'd20, 1'b1);
    chk("u_30_20_brlt", brlt, 1'b0);

    apply(-32'sd10, 32'd5, 1'b0);
    chk("s_m10_5_brlt", brlt, 1'b1);
    apply(32'd10, -32'sd5, 1'b0);
    chk("s_10_m5_brlt", brlt, 1'b0);
    apply(32'd15, 32'd20, 1'b0);
    chk("s_15_20_breq", breq, 1'b0);
    chk("s_15_20_brlt", brlt, 1'b1);

    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("s_min_max_brlt", brlt, 1'b1);
    // Only the mode changes; result must follow without a clock.
    brun = 1'b1;
    #1;
    chk("u_min_max_brlt", brlt, 1'b0);

    apply(32'hFFFF_FFFF, 32'h0, 1'b0);
    chk("s_m1_0_brlt", brlt, 1'b1);
    apply(32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("u_m1_0_brlt", brlt, 1'b0);
    apply(32'h0, 32'hFFFF_FFFF, 1'b1);
    chk("u_0_max_brlt", brlt, 1'b1);

    // Registered path.
    @(negedge clk);
    rst = 1'b0;
    apply(32'd10, 32'd20, 1'b1);
    chk("pre_edge_brlt_q", brlt_q, 1'b0);
    @(posedge clk);
    #1;
    chk("reg_breq_q", breq_q, 1'b0);
    chk("reg_brlt_q", brlt_q, 1'b1);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_breq_q", breq_q, 1'b0);
    chk("async_rst_brlt_q", brlt_q, 1'b0);
    chk("async_rst_brlt", brlt, 1'b1);

    // First edge after release captures current results.
    @(negedge clk);
    rst = 1'b0;
    apply(32'd7, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_breq_q", breq_q, 1'b1);
    chk("post_rst_brlt_q", brlt_q, 1'b0);

    // Randomized comparison against a behavioural reference.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = (i % 8 == 3) ? ra : $urandom;
      if (i % 16 == 5) rb = ra ^ 32'h8000_0000;
      ru = i[0];
      apply(ra, rb, ru);
      exp_lt = ru ? (ra < rb) : ($signed(ra) < $signed(rb));
      chk("rand_breq", breq, ra == rb);
      chk("rand_brlt", brlt, exp_lt);
      chk("rand_excl", breq & brlt, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_branch_comp
